// File: rtl/state_history_logger.sv
// rtl/state_history_logger.sv - debug state history logger with registered indexed read port
// Optional feature macro: STATE_HIST_TIMESTAMP_EN (per-entry free-running timestamp).
module state_history_logger #(
  parameter int BITS    = 8,
  parameter int DEPTH   = 4,
  parameter int TS_BITS = 16,
  localparam int IDXW   = $clog2(DEPTH),
  localparam int CNTW   = $clog2(DEPTH + 1)
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iClear,
  input  logic [BITS-1:0]    iDbgSt,
  input  logic               iFreeze,
  input  logic [IDXW-1:0]    iRdIdx,
  output logic [BITS-1:0]    current_state,
  output logic [BITS-1:0]    oRdData,
  output logic [TS_BITS-1:0] oRdTs,
  output logic               oRdValid,
  output logic [CNTW-1:0]    oCount,
  output logic               ochange,
  output logic               oOverflow,
  output logic               oFrozen
);

  typedef enum logic [1:0] {LOAD, RUN, FROZEN} state_t;

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);

  state_t          state;
  logic [BITS-1:0] hist [DEPTH];
  logic            logging;
  logic            idx_in_range;

  // A new entry is pushed only while running, not clearing, and the bus moved.
  assign logging      = (state == RUN) && !iClear && (iDbgSt != current_state);
  assign idx_in_range = 32'(iRdIdx) < 32'(DEPTH);

  // Control FSM with registered status outputs; clear overrides freeze and change.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state         <= LOAD;
      current_state <= '0;
      oCount        <= '0;
      ochange       <= 1'b0;
      oOverflow     <= 1'b0;
      oFrozen       <= 1'b0;
    end else begin
      if (state == LOAD) begin
        current_state <= iDbgSt;
      end
      if (iClear) begin
        state     <= LOAD;
        oCount    <= '0;
        ochange   <= 1'b0;
        oOverflow <= 1'b0;
        oFrozen   <= 1'b0;
      end else begin
        case (state)
          LOAD: state <= RUN;
          RUN: begin
            if (iDbgSt != current_state) begin
              current_state <= iDbgSt;
              ochange       <= 1'b1;
              if (oCount == CNT_MAX) begin
                oOverflow <= 1'b1;
              end else begin
                oCount <= oCount + CNTW'(1);
              end
            end
            if (iFreeze) begin
              state   <= FROZEN;
              oFrozen <= 1'b1;
            end
          end
          FROZEN: state <= FROZEN;
          default: state <= LOAD;
        endcase
      end
    end
  end

  // History shift register, newest previous state at index 0.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else if (iClear) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else if (logging) begin
      hist[0] <= current_state;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  // Registered read port; samples pre-shift content, out-of-range index reads zero.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRdData  <= '0;
      oRdValid <= 1'b0;
    end else begin
      oRdData  <= idx_in_range ? hist[iRdIdx] : '0;
      oRdValid <= 32'(iRdIdx) < 32'(oCount);
    end
  end

`ifdef STATE_HIST_TIMESTAMP_EN
  logic [TS_BITS-1:0] ts_cnt;
  logic [TS_BITS-1:0] hist_ts [DEPTH];

  // Free-running timestamp; wraps naturally, cleared by iClear, paused while frozen.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ts_cnt <= '0;
    end else if (iClear) begin
      ts_cnt <= '0;
    end else if (state != FROZEN) begin
      ts_cnt <= ts_cnt + TS_BITS'(1);
    end
  end

  // Timestamp history shifts in lockstep with the state history.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int k = 0; k < DEPTH; k++) hist_ts[k] <= '0;
    end else if (iClear) begin
      for (int k = 0; k < DEPTH; k++) hist_ts[k] <= '0;
    end else if (logging) begin
      hist_ts[0] <= ts_cnt;
      for (int k = 1; k < DEPTH; k++) hist_ts[k] <= hist_ts[k-1];
    end
  end

  // Timestamp read with the same one-cycle latency as the data.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRdTs <= '0;
    end else begin
      oRdTs <= idx_in_range ? hist_ts[iRdIdx] : '0;
    end
  end
`else
  assign oRdTs = '0;
`endif

endmodule

// File: doc/state_history_logger.md
Name: state_history_logger

Overview:
- Parametrised successor to the single-entry debug state logger.
- Watches a debug state bus and records the last DEPTH *previous* states in a shift-register history, newest at index 0.
- Adds a saturating change counter, an overflow flag, a freeze-on-fault mode and a registered indexed read port.
- Sits beside power-sequencing and other debug FSMs; the history is read out over the management/SMBus register map after a fault.

Parameters:
- BITS, 8, width of the monitored state bus.
- DEPTH, 4, number of history entries; legal range 2..64.
- TS_BITS, 16, width of the per-entry timestamp (used only with the optional feature).
- Derived, not overridable: IDXW = $clog2(DEPTH); CNTW = $clog2(DEPTH+1).

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  reset; asynchronous, active-low.
- iClear  in  1  synchronous clear of history, counter and flags.
- iDbgSt  in  BITS  monitored state.
- iFreeze  in  1  fault trigger; stops logging until iClear.
- iRdIdx  in  IDXW  history index to read; 0 = most recent previous state.
- current_state  out  BITS  last captured state.
- oRdData  out  BITS  history entry at iRdIdx, registered.
- oRdTs  out  TS_BITS  timestamp of that entry, registered.
- oRdValid  out  1  entry at iRdIdx holds a logged value.
- oCount  out  CNTW  number of valid entries, saturates at DEPTH.
- ochange  out  1  sticky: at least one change logged since reset/clear.
- oOverflow  out  1  sticky: at least one entry shifted out of the oldest slot.
- oFrozen  out  1  logger is in FROZEN.

Behaviour:
- Async reset (iRst_n=0):
  - All history, timestamp and output registers go to 0.
  - FSM goes to LOAD.
- FSM states: LOAD, RUN, FROZEN.
- LOAD:
  - current_state <= iDbgSt; nothing is logged; go to RUN next cycle.
  - iFreeze is ignored in LOAD.
- RUN, when iDbgSt != current_state:
  - hist[k] <= hist[k-1] for k = 1..DEPTH-1; hist[0] <= current_state; current_state <= iDbgSt.
  - ochange <= 1.
  - If oCount < DEPTH: oCount increments. If oCount == DEPTH: the oldest entry is lost, oCount holds and oOverflow <= 1.
- RUN, when iDbgSt == current_state: all registers hold.
- RUN with iFreeze=1:
  - Next state is FROZEN.
  - A change in the same cycle is still logged; freeze takes effect from the next cycle.
- FROZEN:
  - current_state, history, oCount and flags all hold; iDbgSt is ignored.
  - oFrozen = 1. The only exit is iClear.
- iClear=1, any state:
  - History, oCount, ochange, oOverflow and oFrozen are cleared; next state is LOAD.
  - iClear has priority over iFreeze and over a change in the same cycle.
  - iClear held high keeps the block in LOAD, tracking iDbgSt with nothing logged.
- Read port:
  - 1-cycle latency: oRdData <= hist[iRdIdx]; oRdValid <= (iRdIdx < oCount).
  - If iRdIdx >= DEPTH (non-power-of-2 DEPTH): oRdData <= 0 and oRdValid <= 0.
  - A read in the same cycle as a shift returns the pre-shift content.
  - Reads are allowed in every state, including FROZEN.
- Reset asserted mid-operation: history is lost immediately; there is no retention.

Optional Feature:
- Macro: STATE_HIST_TIMESTAMP_EN.
- Defined:
  - A free-running TS_BITS counter runs from reset; it wraps at all-ones to 0, is cleared by iClear, and stops in FROZEN.
  - Each logged entry stores the counter value from its logging cycle; the timestamps shift with the history.
  - oRdTs has the same 1-cycle read latency as oRdData.
- Not defined: no counter and no timestamp storage; oRdTs is tied to 0.

Test Plan:
- Reset release with iDbgSt=0x11 held -> after LOAD: current_state=0x11, oCount=0, ochange=0, oRdValid=0 for all indices.
- iDbgSt sequence 0x11->0x22->0x33, one change per 3 cycles -> current_state=0x33; idx0 reads 0x22 and idx1 reads 0x11, both valid; oCount=2; ochange=1; oOverflow=0.
- Six changes 0x01..0x06 after LOAD at 0x00, DEPTH=4 -> oCount=4; oOverflow=1; idx0..3 read 0x05,0x04,0x03,0x02.
- iFreeze pulsed in the same cycle as change 0x44->0x55, then further changes -> 0x44 logged; current_state stays 0x55; oFrozen=1; history and oCount frozen until iClear.
- iClear and iFreeze together while logging -> oFrozen=0; oCount=0; flags 0; LOAD recaptures iDbgSt.
- With STATE_HIST_TIMESTAMP_EN, TS_BITS=4: change logged at counter 0xE, next at 0x1 after wrap -> oRdTs for idx1=0xE and idx0=0x1; without the macro, oRdTs=0 always.
